// File: rtl/spi_timer_pkg.sv
// Shared constants and frame layout for the SPI timer configuration slave.
package spi_timer_pkg;

    localparam logic [6:0]  ADDR_VALUE = 7'h01;
    localparam logic [6:0]  ADDR_CTRL  = 7'h02;
    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned DATA_BITS  = FRAME_BITS - CMD_BITS;
    localparam int unsigned CNT_W      = 5;

    typedef struct packed {
        logic       rd;
        logic [6:0] addr;
    } cmd_t;

    typedef struct packed {
        cmd_t                 cmd;
        logic [DATA_BITS-1:0] data;
    } frame_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an async pin with registered rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    // Chain clears to 0, so a pin already high after reset yields one rise pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            last_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
            fall   <= ~sync_q[SYNC_STAGES-1] & last_q;
        end
    end

endmodule

// File: rtl/spi_timer_cfg.sv
// SPI mode-0 slave that writes and reads back the period counter's compare value
// and restart control, oversampled in the fabric clock.
module spi_timer_cfg
    import spi_timer_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       DATA_W      = 16,
    parameter logic [DATA_W-1:0] VALUE_RST   = 16'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic              cnt_out,
    output logic [DATA_W-1:0] value,
    output logic              restart,
    output logic              cfg_stb
);

    logic                  sck_rise;
    logic                  sck_fall;
    logic                  cs_rise;
    logic                  cs_fall;
    logic [SYNC_STAGES:0]  mosi_sync;
    logic                  mosi_bit;
    logic                  armed;
    logic                  in_frame;
    logic                  rd_active;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-2:0] shift_in;
    logic [DATA_W-1:0]     shift_out;
    frame_t                frame_c;
    cmd_t                  cmd_c;
    logic [DATA_W-1:0]     rd_word_c;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // One extra mosi stage keeps data aligned with the registered sck edge pulses.
    assign mosi_bit = mosi_sync[SYNC_STAGES];
    assign frame_c  = {shift_in, mosi_bit};
    assign cmd_c    = {shift_in[CMD_BITS-2:0], mosi_bit};

    always_comb begin
        rd_word_c = '0;
        case (cmd_c.addr)
            ADDR_VALUE: rd_word_c = value;
            ADDR_CTRL:  rd_word_c = DATA_W'({cnt_out, restart});
            default:    rd_word_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mosi_sync <= '0;
            armed     <= 1'b0;
            in_frame  <= 1'b0;
            rd_active <= 1'b0;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            spi_miso  <= 1'b0;
            value     <= VALUE_RST;
            restart   <= 1'b0;
            cfg_stb   <= 1'b0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-1:0], spi_mosi};
            cfg_stb   <= 1'b0;
            if (cs_rise) begin
                // End of frame or abort: partial frames are simply dropped.
                armed     <= 1'b1;
                in_frame  <= 1'b0;
                rd_active <= 1'b0;
                bit_cnt   <= '0;
                spi_miso  <= 1'b0;
            end else if (cs_fall) begin
                in_frame  <= armed;
                rd_active <= 1'b0;
                bit_cnt   <= '0;
                shift_in  <= '0;
                shift_out <= '0;
                spi_miso  <= 1'b0;
            end else if (in_frame) begin
                if (sck_rise && (bit_cnt < CNT_W'(FRAME_BITS))) begin
                    shift_in <= {shift_in[FRAME_BITS-3:0], mosi_bit};
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                    if ((bit_cnt == CNT_W'(CMD_BITS - 1)) && cmd_c.rd) begin
                        rd_active <= 1'b1;
                        shift_out <= rd_word_c;
                    end
                    if ((bit_cnt == CNT_W'(FRAME_BITS - 1)) && !frame_c.cmd.rd) begin
                        case (frame_c.cmd.addr)
                            ADDR_VALUE: begin
                                value   <= DATA_W'(frame_c.data);
                                cfg_stb <= 1'b1;
                            end
                            ADDR_CTRL: begin
                                restart <= frame_c.data[0];
                                cfg_stb <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                if (sck_fall) begin
                    if (rd_active && (bit_cnt >= CNT_W'(CMD_BITS))
                                  && (bit_cnt < CNT_W'(FRAME_BITS))) begin
                        spi_miso  <= shift_out[DATA_W-1];
                        shift_out <= {shift_out[DATA_W-2:0], 1'b0};
                    end else begin
                        spi_miso  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_timer_cfg.sv
// Directed bench for spi_timer_cfg: writes, readbacks, aborts, mid-frame reset, long frames.
module tb_spi_timer_cfg;

    logic        clk;
    logic        rst_n;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        cnt_out;
    logic [15:0] value;
    logic        restart;
    logic        cfg_stb;

    int checks   = 0;
    int failures = 0;
    int stb_cnt  = 0;
    int stb_base = 0;
    logic [31:0] rx;

    spi_timer_cfg #(.SYNC_STAGES(2), .DATA_W(16), .VALUE_RST(16'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .cnt_out  (cnt_out),
        .value    (value),
        .restart  (restart),
        .cfg_stb  (cfg_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (cfg_stb === 1'b1) stb_cnt <= stb_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master transfer: mosi set while sck low, miso sampled at each sck rise.
    task automatic spi_xfer(input logic [31:0] tx, input int nbits, input int rst_at,
                            input bit lat_chk, input logic [15:0] lat_old,
                            input logic [15:0] lat_new, output logic [31:0] rx_o);
        rx_o = '0;
        spi_cs_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                wait_clk(3);
                rst_n = 1'b1;
                chk("rst_mid_value", 32'(value), 32'h0);
            end
            spi_mosi = tx[nbits-1-i];
            wait_clk(8);
            spi_sck = 1'b1;
            rx_o = {rx_o[30:0], spi_miso};
            if (lat_chk && i == 23) begin
                wait_clk(3);
                chk("lat_pre", 32'(value), 32'(lat_old));
                wait_clk(1);
                chk("lat_post", 32'(value), 32'(lat_new));
                chk("lat_stb", 32'(cfg_stb), 32'h1);
                wait_clk(4);
            end else begin
                wait_clk(8);
            end
            spi_sck = 1'b0;
        end
        wait_clk(8);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(12);
    endtask

    task automatic xfer24(input logic [23:0] fr, output logic [31:0] rx_o);
        spi_xfer(32'(fr), 24, -1, 1'b0, 16'h0, 16'h0, rx_o);
    endtask

    initial begin
        rst_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; cnt_out = 1'b0;
        wait_clk(4);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_restart", 32'(restart), 32'h0);
        chk("rst_stb", 32'(cfg_stb), 32'h0);
        chk("rst_miso", 32'(spi_miso), 32'h0);
        rst_n = 1'b1;
        wait_clk(10);

        // Write value with edge-accurate latency check.
        stb_base = stb_cnt;
        spi_xfer(32'h00011234, 24, -1, 1'b1, 16'h0000, 16'h1234, rx);
        chk("w1_value", 32'(value), 32'h1234);
        chk("w1_stb_cnt", 32'(stb_cnt - stb_base), 32'd1);
        chk("w1_restart", 32'(restart), 32'h0);

        // Control write then status readback with cnt_out high.
        stb_base = stb_cnt;
        xfer24(24'h020001, rx);
        chk("w2_restart", 32'(restart), 32'h1);
        chk("w2_stb_cnt", 32'(stb_cnt - stb_base), 32'd1);
        cnt_out = 1'b1;
        stb_base = stb_cnt;
        xfer24(24'h820000, rx);
        chk("r82_word", 32'(rx[15:0]), 32'h0003);
        chk("r82_stb_cnt", 32'(stb_cnt - stb_base), 32'd0);
        chk("r82_miso_idle", 32'(spi_miso), 32'h0);
        cnt_out = 1'b0;

        // Value readback is side-effect free.
        stb_base = stb_cnt;
        xfer24(24'h81FFFF, rx);
        chk("r81_word", 32'(rx[15:0]), 32'h1234);
        chk("r81_value", 32'(value), 32'h1234);
        chk("r81_stb_cnt", 32'(stb_cnt - stb_base), 32'd0);

        // Aborted write after 20 bits, then a complete one.
        stb_base = stb_cnt;
        spi_xfer(32'h0001AAAA >> 4, 20, -1, 1'b0, 16'h0, 16'h0, rx);
        chk("abort_value", 32'(value), 32'h1234);
        chk("abort_stb_cnt", 32'(stb_cnt - stb_base), 32'd0);
        xfer24(24'h015555, rx);
        chk("post_abort_value", 32'(value), 32'h5555);

        // Reset in the middle of a write frame.
        stb_base = stb_cnt;
        spi_xfer(32'h0001BEEF, 24, 10, 1'b0, 16'h0, 16'h0, rx);
        chk("rst_frame_value", 32'(value), 32'h0);
        chk("rst_frame_restart", 32'(restart), 32'h0);
        chk("rst_frame_stb_cnt", 32'(stb_cnt - stb_base), 32'd0);
        xfer24(24'h010F0F, rx);
        chk("post_rst_value", 32'(value), 32'h0F0F);

        // Unmapped address: no write, zero readback.
        stb_base = stb_cnt;
        xfer24(24'h05FFFF, rx);
        chk("a05_value", 32'(value), 32'h0F0F);
        chk("a05_restart", 32'(restart), 32'h0);
        chk("a05_stb_cnt", 32'(stb_cnt - stb_base), 32'd0);
        xfer24(24'h850000, rx);
        chk("r85_word", 32'(rx[15:0]), 32'h0000);

        // 30-bit frames: only the first 24 bits count, trailing miso is low.
        stb_base = stb_cnt;
        spi_xfer({2'b00, 24'h014321, 6'b111111}, 30, -1, 1'b0, 16'h0, 16'h0, rx);
        chk("long_w_value", 32'(value), 32'h4321);
        chk("long_w_stb_cnt", 32'(stb_cnt - stb_base), 32'd1);
        spi_xfer({2'b00, 24'h810000, 6'b000000}, 30, -1, 1'b0, 16'h0, 16'h0, rx);
        chk("long_r_word", 32'(rx[21:6]), 32'h4321);
        chk("long_r_tail", 32'(rx[5:0]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
